sdp_stream_fifo: RTL and testbench

Synchronous ready/valid stream FIFO built around the team's simple-dual-port RAM primitive RAMSDP, which has a 2-cycle registered read and internal same-cycle write-to-read forwarding. The block generates the RAM write and read addresses and write enables. It hides the RAM read latency behind a small output skid buffer, so a downstream consumer sees full one-word-per-cycle throughput. It sits directly upstream of the RAM and is the only block that writes or reads it.

---
 rtl/sdp_stream_pkg.sv | 12 +
 rtl/RAMSDP.sv | 37 +++
 rtl/sdp_skid_buffer.sv | 48 ++++
 rtl/sdp_stream_fifo.sv | 116 +++++++++++
 tb/tb_sdp_stream_fifo.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdp_stream_pkg.sv
// Shared constants and pointer arithmetic for the RAMSDP-backed stream FIFO.
package sdp_stream_pkg;

    localparam int SKID_DEPTH = 4;
    localparam int RD_LATENCY = 2;

    // Callers truncate the result to their pointer width, which gives the modular difference.
    function automatic logic [31:0] ptr_diff(input logic [31:0] wr, input logic [31:0] rd);
        return wr - rd;
    endfunction

endpackage

// File: rtl/RAMSDP.sv
// Behavioural model of the simple-dual-port RAM primitive: registered read address,
// registered q (2-cycle read) and same-cycle write-to-read forwarding.
module RAMSDP #(
    parameter int    bus_width  = 8,
    parameter int    addr_width = 4,
    parameter string device     = "Cyclone V"
) (
    input  logic                  clock,
    input  logic [bus_width-1:0]  data,
    input  logic [addr_width-1:0] wraddress,
    input  logic                  wren,
    input  logic [addr_width-1:0] rdaddress,
    output logic [bus_width-1:0]  q
);

    localparam bit FWD_NEW_DATA = (device != "");

    logic [bus_width-1:0]  r_mem [2**addr_width];
    logic [addr_width-1:0] r_rd_addr;
    logic                  r_fwd;
    logic [bus_width-1:0]  r_fwd_data;
    logic [bus_width-1:0]  r_q;

    // Write port, address register with forwarding capture, output register.
    always_ff @(posedge clock) begin
        if (wren) begin
            r_mem[wraddress] <= data;
        end
        r_rd_addr  <= rdaddress;
        r_fwd      <= FWD_NEW_DATA && wren && (wraddress == rdaddress);
        r_fwd_data <= data;
        r_q        <= r_fwd ? r_fwd_data : r_mem[r_rd_addr];
    end

    assign q = r_q;

endmodule

// File: rtl/sdp_skid_buffer.sv
// Small circular FIFO holding words already read out of the RAM; head is combinational.
module sdp_skid_buffer #(
    parameter int bus_width = 8,
    parameter int depth     = 4
) (
    input  logic                         i_clock,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic [bus_width-1:0]         i_push_data,
    input  logic                         i_pop,
    output logic [bus_width-1:0]         o_head,
    output logic [$clog2(depth+1)-1:0]   o_count
);

    localparam int IW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    logic [bus_width-1:0] r_mem [depth];
    logic [IW-1:0]        r_wr_idx;
    logic [IW-1:0]        r_rd_idx;
    logic [CW-1:0]        r_count;

    // Storage, indices and occupancy; clear has priority over push/pop.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_idx] <= i_push_data;
                r_wr_idx        <= r_wr_idx + IW'(1);
            end
            if (i_pop) begin
                r_rd_idx <= r_rd_idx + IW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_idx];
    assign o_count = r_count;

endmodule

// File: rtl/sdp_stream_fifo.sv
// Ready/valid stream FIFO on RAMSDP; a skid buffer hides the 2-cycle read latency
// so the consumer sees one word per cycle.
module sdp_stream_fifo
    import sdp_stream_pkg::*;
#(
    parameter int    bus_width  = 8,
    parameter int    addr_width = 4,
    parameter string device     = "Cyclone V"
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [bus_width-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [bus_width-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [addr_width+1:0] level
);

    localparam int PW  = addr_width + 1;
    localparam int LW  = addr_width + 2;
    localparam int SCW = $clog2(SKID_DEPTH + 1);
    localparam int IFW = $clog2(RD_LATENCY + 1);
    localparam int OW  = SCW + 1;

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [RD_LATENCY-1:0] r_rd_vld;
    logic [LW-1:0]         r_level;
    logic [PW-1:0]         w_ram_count;
    logic [IFW-1:0]        w_inflight;
    logic [SCW-1:0]        w_skid_count;
    logic [bus_width-1:0]  w_ram_q;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_clear;

    // RAM occupancy from the registered pointers and number of reads still in the pipeline.
    always_comb begin
        w_ram_count = PW'(ptr_diff(32'(r_wr_ptr), 32'(r_rd_ptr)));
        w_inflight  = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + IFW'(r_rd_vld[i]);
        end
    end

    assign w_full   = (w_ram_count == PW'(2**addr_width));
    assign in_ready = !reset && !flush && !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;
    assign w_clear  = reset || flush;
    assign w_push   = r_rd_vld[RD_LATENCY-1];

    // Issue only when the skid is guaranteed room for every read already committed;
    // a pop this cycle frees one slot.
    assign w_issue = (w_ram_count != '0) &&
                     ((OW'(w_skid_count) + OW'(w_inflight)) < (OW'(SKID_DEPTH) + OW'(w_pop)));

    // Pointers, read-pipeline valids and the registered level count.
    always_ff @(posedge clock) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rd_vld <= '0;
            r_level  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_rd_vld <= {r_rd_vld[RD_LATENCY-2:0], w_issue};
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    RAMSDP #(
        .bus_width  (bus_width),
        .addr_width (addr_width),
        .device     (device)
    ) u_ram (
        .clock      (clock),
        .data       (in_data),
        .wraddress  (r_wr_ptr[addr_width-1:0]),
        .wren       (w_accept),
        .rdaddress  (r_rd_ptr[addr_width-1:0]),
        .q          (w_ram_q)
    );

    sdp_skid_buffer #(
        .bus_width  (bus_width),
        .depth      (SKID_DEPTH)
    ) u_skid (
        .i_clock     (clock),
        .i_clear     (w_clear),
        .i_push      (w_push),
        .i_push_data (w_ram_q),
        .i_pop       (w_pop),
        .o_head      (out_data),
        .o_count     (w_skid_count)
    );

    assign out_valid = (w_skid_count != '0);
    assign level     = r_level;

endmodule

// File: tb/tb_sdp_stream_fifo.sv
// Self-checking bench for sdp_stream_fifo: queue-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_sdp_stream_fifo;

    localparam int BW      = 8;
    localparam int AW      = 4;
    localparam int RAM_CAP = 16;
    localparam int SKID    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW+1:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    sdp_stream_fifo #(.bus_width(BW), .addr_width(AW), .device("Cyclone V")) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words waiting in RAM, reads in flight (with issue cycle), words in skid.
    typedef struct { logic [BW-1:0] d; int t; } fl_t;
    logic [BW-1:0] ram_q[$];
    logic [BW-1:0] skid_q[$];
    fl_t           fl_q[$];
    int            cyc = 0;
    bit            started = 1'b0;

    function automatic bit m_in_ready();
        return !reset && !flush && (ram_q.size() < RAM_CAP);
    endfunction

    always @(posedge clock) begin : p_model
        automatic bit  acc;
        automatic bit  pop;
        automatic bit  iss;
        automatic fl_t e;
        if (reset || flush) begin
            ram_q.delete();
            skid_q.delete();
            fl_q.delete();
        end else begin
            acc = in_valid && m_in_ready();
            pop = (skid_q.size() != 0) && out_ready;
            iss = (ram_q.size() != 0) && ((skid_q.size() + fl_q.size() - int'(pop)) < SKID);
            if (pop) void'(skid_q.pop_front());
            if (fl_q.size() != 0 && fl_q[0].t == cyc - 2) begin
                e = fl_q.pop_front();
                skid_q.push_back(e.d);
            end
            if (iss) begin
                e.d = ram_q.pop_front();
                e.t = cyc;
                fl_q.push_back(e);
            end
            if (acc) ram_q.push_back(in_data);
        end
        cyc     <= cyc + 1;
        started <= 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (started) begin
            check("in_ready", 32'(in_ready), 32'(m_in_ready()));
            check("out_valid", 32'(out_valid), 32'(skid_q.size() != 0));
            if (skid_q.size() != 0) check("out_data", 32'(out_data), 32'(skid_q[0]));
            check("level", 32'(level), 32'(ram_q.size() + fl_q.size() + skid_q.size()));
        end
    end

    logic [BW-1:0] got[$];
    always @(negedge clock) begin
        if (out_valid && out_ready) got.push_back(out_data);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int acc_n;
        int vcount;
        int bad;

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);

        // Single word latency
        tick();
        in_data = 8'hA5; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clock); check("t1_valid_e0", 32'(out_valid), 32'd0); tick();
        @(negedge clock); check("t1_valid_e1", 32'(out_valid), 32'd0); tick();
        @(negedge clock); check("t1_valid_e2", 32'(out_valid), 32'd0); tick();
        @(negedge clock);
        check("t1_valid_e3", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'hA5);
        check("t1_level_e3", 32'(level), 32'd1);
        tick();
        @(negedge clock);
        check("t1_level_end", 32'(level), 32'd0);
        check("t1_valid_end", 32'(out_valid), 32'd0);

        // Fill with consumer stalled
        tick();
        out_ready = 1'b0;
        acc_n = 0;
        for (int w = 0; w < 26; w++) begin
            in_data = 8'(w); in_valid = 1'b1;
            @(negedge clock);
            if (in_ready) acc_n++;
            if (w == 20) check("fill_ready_21st", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("fill_accepted", 32'(acc_n), 32'd20);
        repeat (3) tick();
        @(negedge clock);
        check("fill_level", 32'(level), 32'd20);
        check("fill_ready_full", 32'(in_ready), 32'd0);
        got.delete();
        tick();
        out_ready = 1'b1;
        @(negedge clock); check("drain_ready_before", 32'(in_ready), 32'd0);
        tick();
        @(negedge clock); check("drain_ready_after", 32'(in_ready), 32'd1);
        repeat (30) tick();
        check("drain_count", 32'(got.size()), 32'd20);
        bad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] != 8'(i)) bad++;
        check("drain_order", 32'(bad), 32'd0);

        // Streaming at full rate
        got.delete();
        vcount = 0;
        for (int i = 0; i < 100; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            @(negedge clock);
            if (out_valid) vcount++;
            tick();
        end
        in_valid = 1'b0;
        check("stream_valid_cycles", 32'(vcount), 32'd96);
        repeat (10) tick();
        check("stream_count", 32'(got.size()), 32'd100);
        bad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] != 8'(i)) bad++;
        check("stream_order", 32'(bad), 32'd0);

        // Random traffic and backpressure
        for (int i = 0; i < 2000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            @(negedge clock);
            check("rand_level_max", 32'(level <= 6'd20), 32'd1);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) tick();
        @(negedge clock);
        check("rand_drained", 32'(level), 32'd0);

        // Flush with two reads in flight
        tick();
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h80 + 8'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clock);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clock);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_level", 32'(level), 32'd0);
        got.delete();
        tick();
        in_data = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        check("flush_after_count", 32'(got.size()), 32'd1);
        if (got.size() != 0) check("flush_after_data", 32'(got[0]), 32'h3C);

        // Reset in the middle of traffic
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_data = 8'h40 + 8'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        @(negedge clock);
        check("mid_level", 32'(level), 32'd12);
        tick();
        reset = 1'b1;
        @(negedge clock); check("mid_rst_ready0", 32'(in_ready), 32'd0);
        tick();
        @(negedge clock);
        check("mid_rst_ready1", 32'(in_ready), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("mid_post_level", 32'(level), 32'd0);
        check("mid_post_valid", 32'(out_valid), 32'd0);
        check("mid_post_ready", 32'(in_ready), 32'd1);
        got.delete();
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h50 + 8'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        check("mid_post_count", 32'(got.size()), 32'd3);
        bad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] != 8'h50 + 8'(i)) bad++;
        check("mid_post_order", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
